// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues word fetches to instruction memory,
// tags each in-flight request with its PC and buffers returned instructions in an
// in-order queue presented to decode through a valid/ready handshake. A redirect
// flushes the queue and drops every response that is still in flight.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  // Counters must reach DEPTH itself, hence one extra bit.
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Program counter.
  logic [31:0]   pc_q, pc_d;

  // Instruction queue: one {instr, pc} entry per buffered response.
  logic [31:0]   q_instr_q [DEPTH];
  logic [31:0]   q_pc_q    [DEPTH];
  logic [PW-1:0] q_wr_q, q_wr_d;
  logic [PW-1:0] q_rd_q, q_rd_d;
  logic [CW-1:0] count_q, count_d;

  // PC tags of accepted requests, popped one per response.
  logic [31:0]   tag_q [DEPTH];
  logic [PW-1:0] tag_wr_q, tag_wr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d;

  // Requests accepted but not yet answered, and responses still to be dropped.
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          credit_ok;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_keep;
  logic          pop;
  logic [31:0]   rsp_tag;
  logic [31:0]   redirect_word;

  // Handshake decode and outputs toward memory and decode.
  always_comb begin
    // Credit uses the registered count: a same-cycle pop does not free a slot yet.
    credit_ok      = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_W;
    imem_req_valid = !rst && credit_ok && !redirect_valid;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // Guard keeps the counters sane if memory ever answers with nothing pending.
    rsp_take       = imem_rsp_valid && (outstanding_q != '0);
    rsp_keep       = rsp_take && (discard_q == '0) && !redirect_valid;
    rsp_tag        = tag_q[tag_rd_q];
    redirect_word  = redirect_pc & 32'hFFFF_FFFC;
    id_valid       = (count_q != '0);
    id_instr       = id_valid ? q_instr_q[q_rd_q] : NOP;
    id_pc          = id_valid ? q_pc_q[q_rd_q] : 32'h0000_0000;
    pop            = id_valid && id_ready;
  end

  // Next-state for PC, counters and pointers.
  always_comb begin
    pc_d          = pc_q;
    q_wr_d        = q_wr_q;
    q_rd_d        = q_rd_q;
    count_d       = count_q;
    tag_wr_d      = tag_wr_q + PW'(req_fire);
    tag_rd_d      = tag_rd_q + PW'(rsp_take);
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    discard_d     = discard_q;

    if (redirect_valid) begin
      pc_d    = redirect_word;
      q_wr_d  = '0;
      q_rd_d  = '0;
      count_d = '0;
      // Everything still in flight after this cycle belongs to the old path; a
      // response arriving now is already gone with the flushed queue.
      discard_d = outstanding_d;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_take && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      q_wr_d  = q_wr_q + PW'(rsp_keep);
      q_rd_d  = q_rd_q + PW'(pop);
      count_d = count_q + CW'(rsp_keep) - CW'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      q_wr_q        <= '0;
      q_rd_q        <= '0;
      count_q       <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      q_wr_q        <= q_wr_d;
      q_rd_q        <= q_rd_d;
      count_q       <= count_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Storage arrays; contents are only visible through valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_q[tag_wr_q] <= pc_q;
    end
    if (rsp_keep) begin
      q_instr_q[q_wr_q] <= imem_rsp_data;
      q_pc_q[q_wr_q]    <= rsp_tag;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order instruction memory model with configurable latency
// and random accept, scoreboard of the expected fetch stream, decoupled monitor.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_queue #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          passes = 0;
  item_t       exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          ready_pct = 100;
  int          max_out = 0;
  int          pops = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Expected fetch stream: consecutive words from the start PC, wrapping at 2^32.
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{pc: a, instr: mem_word(a)});
      a = a + 32'd4;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle out of reset.
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    step(2);
    @(negedge clk);
    #1;
    load_stream(RESET_PC);
    acc_addr.delete();
    acc_cyc.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Called at posedge+1; redirect is live for exactly one cycle.
  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    #1;
    load_stream(target & 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  // Instruction memory: in-order, fixed latency per request, no response backpressure.
  initial begin
    int o;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        o = pend_q.size() + (imem_rsp_valid ? 1 : 0);
        if (o > max_out) max_out = o;
        if (imem_req_valid && imem_req_ready) begin
          pend_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
          acc_addr.push_back(imem_req_addr);
          acc_cyc.push_back(cyc);
        end
      end
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
        pend_q.delete();
        imem_rsp_valid = 1'b0;
      end else if (pend_q.size() > 0 && cyc >= pend_q[0].due) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      imem_req_ready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  // Monitor: compares every decode handshake against the scoreboard head.
  initial begin
    logic        stall_prev;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    item_t       e;
    stall_prev = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stall_prev) begin
          check32("stall_valid", {31'b0, id_valid}, 32'd1);
          check32("stall_pc", id_pc, prev_pc);
          check32("stall_instr", id_instr, prev_instr);
        end
        if (id_valid && id_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL sb_empty: got delivery pc %h, expected none", id_pc);
          end else begin
            e = exp_q.pop_front();
            check32("id_pc", id_pc, e.pc);
            check32("id_instr", id_instr, e.instr);
          end
        end else if (!id_valid) begin
          check32("idle_instr", id_instr, NOP);
          check32("idle_pc", id_pc, 32'h0);
        end
      end
      stall_prev = !rst && id_valid && !id_ready && !redirect_valid;
      prev_pc    = id_pc;
      prev_instr = id_instr;
    end
  end

  initial begin
    int p0;
    int since;
    rst = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Reset values.
    step(2);
    @(negedge clk);
    check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check32("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check32("rst_id_instr", id_instr, NOP);
    check32("rst_id_pc", id_pc, 32'h0);
    @(posedge clk);
    #1;

    // Single-cycle memory, decode always ready.
    do_reset();
    @(negedge clk);
    check32("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check32("first_req_addr", imem_req_addr, RESET_PC);
    check32("c0_id_valid", {31'b0, id_valid}, 32'd0);
    @(negedge clk);
    check32("c1_id_valid", {31'b0, id_valid}, 32'd0);
    @(negedge clk);
    check32("c2_id_valid", {31'b0, id_valid}, 32'd1);
    check32("c2_id_pc", id_pc, RESET_PC);
    @(posedge clk);
    #1;
    p0 = pops;
    step(10);
    check32("throughput", 32'(pops - p0), 32'd10);
    check32("req_count_ge8", {31'b0, acc_addr.size() >= 8}, 32'd1);
    for (int i = 0; i < 8 && i < acc_addr.size(); i++) begin
      check32("seq_addr", acc_addr[i], RESET_PC + 32'(4 * i));
      check32("seq_cycle", 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
    end

    // Decode stalled: requests stop at the credit limit, then drain in order.
    id_ready = 1'b0;
    do_reset();
    step(10);
    check32("stall_req_count", 32'(acc_addr.size()), 32'd4);
    if (acc_addr.size() == 4) check32("stall_last_addr", acc_addr[3], 32'hC);
    p0 = pops;
    id_ready = 1'b1;
    step(8);
    check32("drain_ge4", {31'b0, (pops - p0) >= 4}, 32'd1);

    // Three-cycle memory, redirect with requests in flight.
    mem_lat = 3;
    do_reset();
    step(3);
    redirect_to(32'h100);
    p0 = pops;
    step(12);
    check32("lat3_delivered", {31'b0, (pops - p0) >= 2}, 32'd1);

    // Redirect colliding with a response, a pop and a would-be request.
    mem_lat = 1;
    do_reset();
    step(6);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    check32("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
    check32("redir_pop_live", {31'b0, id_valid}, 32'd1);
    #1;
    load_stream(32'h100);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    check32("post_redir_valid", {31'b0, imem_req_valid}, 32'd1);
    check32("post_redir_addr", imem_req_addr, 32'h100);
    @(posedge clk);
    #1;
    step(6);

    // Unaligned redirect target.
    redirect_to(32'h203);
    @(negedge clk);
    check32("align_addr", imem_req_addr, 32'h200);
    @(posedge clk);
    #1;
    step(6);

    // PC wrap.
    redirect_to(32'hFFFF_FFFC);
    @(negedge clk);
    check32("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check32("wrap_addr1", imem_req_addr, 32'h0000_0000);
    @(posedge clk);
    #1;
    step(6);

    // Randomized traffic with redirects and occasional resets.
    since = 0;
    for (int i = 0; i < 1500; i++) begin
      id_ready = ($urandom_range(3) != 0);
      if ($urandom_range(49) == 0) begin
        mem_lat   = int'($urandom_range(4, 1));
        ready_pct = int'($urandom_range(100, 50));
      end
      if ($urandom_range(399) == 0) begin
        do_reset();
        since = 0;
      end else if ($urandom_range(39) == 0 || since > 200) begin
        redirect_to($urandom());
        since = 0;
      end else begin
        step(1);
        since++;
      end
    end
    id_ready = 1'b1;
    step(10);
    check32("max_outstanding", {31'b0, max_out <= int'(DEPTH)}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
